stage_execute_mc: RTL and testbench

//  Parametrised EX pipeline stage: operand forwarding, single-cycle ALU, branch resolution, and EX/MEM register.

---
 rtl/stage_execute_mc.sv | 271 +++++++++++++++++++++++++++
 tb/tb_stage_execute_mc.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_execute_mc.sv
// EX stage: operand forwarding, ALU, branch resolution and EX/MEM register.
// Iterative shift-add multiplier (MUL/MULHU) stalls upstream through ex_busy.
module stage_execute_mc #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MUL_STEP   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_clear,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_write,
    input  logic                  ex_jump,
    input  logic                  ex_jump_cond,
    input  logic [2:0]            ex_jump_cond_type,
    input  logic [3:0]            ex_alu_control,
    input  logic                  ex_alu_src,
    input  logic [1:0]            ex_result_src,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic [XLEN-1:0]       ex_pc_plus_4,
    input  logic [XLEN-1:0]       ex_imm_ext,
    input  logic [XLEN-1:0]       ex_rd1,
    input  logic [XLEN-1:0]       ex_rd2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       wb_result,
    input  logic [1:0]            ex_op1_forward,
    input  logic [1:0]            ex_op2_forward,
    output logic                  ex_busy,
    output logic                  ex_pc_src,
    output logic [XLEN-1:0]       ex_pc_target,
    output logic                  mem_reg_write,
    output logic                  mem_mem_write,
    output logic [1:0]            mem_result_src,
    output logic [XLEN-1:0]       mem_alu_result,
    output logic [XLEN-1:0]       mem_write_data,
    output logic [XLEN-1:0]       mem_pc_plus_4,
    output logic [XLEN-1:0]       mem_imm_ext,
    output logic [REG_ADDR_W-1:0] mem_rd
);

    localparam int N     = XLEN / MUL_STEP;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int SH_W  = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    logic [XLEN-1:0]   op1_fwd;
    logic [XLEN-1:0]   op2_fwd;
    logic [XLEN-1:0]   src_b;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   mul_result;
    logic [XLEN-1:0]   alu_result;
    logic [SH_W-1:0]   shamt;
    logic              cond_true;
    logic              is_mul;
    logic              busy_raw;
    logic              bubble;
    logic [2*XLEN-1:0] partial;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic              hi_q, hi_d;

    logic                  mem_reg_write_q, mem_reg_write_d;
    logic                  mem_mem_write_q, mem_mem_write_d;
    logic [1:0]            mem_result_src_q, mem_result_src_d;
    logic [XLEN-1:0]       mem_alu_result_q, mem_alu_result_d;
    logic [XLEN-1:0]       mem_write_data_q, mem_write_data_d;
    logic [XLEN-1:0]       mem_pc_plus_4_q, mem_pc_plus_4_d;
    logic [XLEN-1:0]       mem_imm_ext_q, mem_imm_ext_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;

    assign is_mul = (ex_alu_control[3:1] == 3'b100);

    // Forwarding muxes: 01 takes WB, 10 takes MEM, anything else the register file
    always_comb begin
        op1_fwd = ex_rd1;
        op2_fwd = ex_rd2;
        case (ex_op1_forward)
            2'b01:   op1_fwd = wb_result;
            2'b10:   op1_fwd = mem_alu_result_q;
            default: op1_fwd = ex_rd1;
        endcase
        case (ex_op2_forward)
            2'b01:   op2_fwd = wb_result;
            2'b10:   op2_fwd = mem_alu_result_q;
            default: op2_fwd = ex_rd2;
        endcase
    end

    assign src_b = ex_alu_src ? ex_imm_ext : op2_fwd;
    assign shamt = src_b[SH_W-1:0];

    // Single-cycle ALU on the low three control bits
    always_comb begin
        alu_out = '0;
        case (ex_alu_control[2:0])
            3'b000: alu_out = op1_fwd + src_b;
            3'b001: alu_out = op1_fwd - src_b;
            3'b010: alu_out = op1_fwd & src_b;
            3'b011: alu_out = op1_fwd | src_b;
            3'b100: alu_out = op1_fwd ^ src_b;
            3'b101: alu_out = {{(XLEN-1){1'b0}},
                               ($signed(op1_fwd) < $signed(src_b))};
            3'b110: alu_out = op1_fwd << shamt;
            3'b111: alu_out = op1_fwd >> shamt;
            default: alu_out = '0;
        endcase
    end

    // Branch condition, RISC-V funct3 encoding on the forwarded operands
    always_comb begin
        cond_true = 1'b0;
        case (ex_jump_cond_type)
            3'b000: cond_true = (op1_fwd == op2_fwd);
            3'b001: cond_true = (op1_fwd != op2_fwd);
            3'b100: cond_true = ($signed(op1_fwd) < $signed(op2_fwd));
            3'b101: cond_true = ($signed(op1_fwd) >= $signed(op2_fwd));
            3'b110: cond_true = (op1_fwd < op2_fwd);
            3'b111: cond_true = (op1_fwd >= op2_fwd);
            default: cond_true = 1'b0;
        endcase
    end

    assign ex_pc_target = ex_pc + ex_imm_ext;
    assign ex_pc_src = ((ex_jump_cond & cond_true) | ex_jump)
                       & ~reset & ~is_mul;

    // Sum of MUL_STEP shifted partial products for this iteration
    always_comb begin
        partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier_q[j]) begin
                partial = partial + (mcand_q << j);
            end
        end
    end

    // Multiplier FSM: IDLE latches operands, BUSY iterates, DONE presents result
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        busy_raw = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul && !mem_clear) begin
                    busy_raw = 1'b1;
                    state_d  = BUSY;
                    cnt_d    = '0;
                    mcand_d  = {{XLEN{1'b0}}, op1_fwd};
                    mplier_d = op2_fwd;
                    acc_d    = '0;
                    hi_d     = ex_alu_control[0];
                end
            end
            BUSY: begin
                busy_raw = 1'b1;
                acc_d    = acc_q + partial;
                mcand_d  = mcand_q << MUL_STEP;
                mplier_d = mplier_q >> MUL_STEP;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (mem_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // A flush cancels any stall request; reset forces it low asynchronously
    assign ex_busy = busy_raw & ~mem_clear & ~reset;

    assign mul_result = hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    assign alu_result = (state_q == DONE) ? mul_result : alu_out;
    assign bubble     = busy_raw | mem_clear;

    // Next EX/MEM contents: bubble while stalled or flushed
    always_comb begin
        mem_reg_write_d  = 1'b0;
        mem_mem_write_d  = 1'b0;
        mem_result_src_d = '0;
        mem_alu_result_d = '0;
        mem_write_data_d = '0;
        mem_pc_plus_4_d  = '0;
        mem_imm_ext_d    = '0;
        mem_rd_d         = '0;
        if (!bubble) begin
            mem_reg_write_d  = ex_reg_write;
            mem_mem_write_d  = ex_mem_write;
            mem_result_src_d = ex_result_src;
            mem_alu_result_d = alu_result;
            mem_write_data_d = op2_fwd;
            mem_pc_plus_4_d  = ex_pc_plus_4;
            mem_imm_ext_d    = ex_imm_ext;
            mem_rd_d         = ex_rd;
        end
    end

    // Multiplier state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_reg_write_q  <= 1'b0;
            mem_mem_write_q  <= 1'b0;
            mem_result_src_q <= '0;
            mem_alu_result_q <= '0;
            mem_write_data_q <= '0;
            mem_pc_plus_4_q  <= '0;
            mem_imm_ext_q    <= '0;
            mem_rd_q         <= '0;
        end else begin
            mem_reg_write_q  <= mem_reg_write_d;
            mem_mem_write_q  <= mem_mem_write_d;
            mem_result_src_q <= mem_result_src_d;
            mem_alu_result_q <= mem_alu_result_d;
            mem_write_data_q <= mem_write_data_d;
            mem_pc_plus_4_q  <= mem_pc_plus_4_d;
            mem_imm_ext_q    <= mem_imm_ext_d;
            mem_rd_q         <= mem_rd_d;
        end
    end

    assign mem_reg_write  = mem_reg_write_q;
    assign mem_mem_write  = mem_mem_write_q;
    assign mem_result_src = mem_result_src_q;
    assign mem_alu_result = mem_alu_result_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_pc_plus_4  = mem_pc_plus_4_q;
    assign mem_imm_ext    = mem_imm_ext_q;
    assign mem_rd         = mem_rd_q;

endmodule

// File: tb/tb_stage_execute_mc.sv
// Directed bench for stage_execute_mc (XLEN=32, MUL_STEP=1).
// Hand-computed vectors for ALU, forwarding, branch, multiply, flush, reset.
module tb_stage_execute_mc;

    logic        clk;
    logic        reset;
    logic        mem_clear;
    logic        ex_reg_write;
    logic        ex_mem_write;
    logic        ex_jump;
    logic        ex_jump_cond;
    logic [2:0]  ex_jump_cond_type;
    logic [3:0]  ex_alu_control;
    logic        ex_alu_src;
    logic [1:0]  ex_result_src;
    logic [31:0] ex_pc;
    logic [31:0] ex_pc_plus_4;
    logic [31:0] ex_imm_ext;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [4:0]  ex_rd;
    logic [31:0] wb_result;
    logic [1:0]  ex_op1_forward;
    logic [1:0]  ex_op2_forward;
    logic        ex_busy;
    logic        ex_pc_src;
    logic [31:0] ex_pc_target;
    logic        mem_reg_write;
    logic        mem_mem_write;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_write_data;
    logic [31:0] mem_pc_plus_4;
    logic [31:0] mem_imm_ext;
    logic [4:0]  mem_rd;

    int checks;
    int errors;
    int busy_n;
    bit bub_ok;

    stage_execute_mc dut (
        .clk               (clk),
        .reset             (reset),
        .mem_clear         (mem_clear),
        .ex_reg_write      (ex_reg_write),
        .ex_mem_write      (ex_mem_write),
        .ex_jump           (ex_jump),
        .ex_jump_cond      (ex_jump_cond),
        .ex_jump_cond_type (ex_jump_cond_type),
        .ex_alu_control    (ex_alu_control),
        .ex_alu_src        (ex_alu_src),
        .ex_result_src     (ex_result_src),
        .ex_pc             (ex_pc),
        .ex_pc_plus_4      (ex_pc_plus_4),
        .ex_imm_ext        (ex_imm_ext),
        .ex_rd1            (ex_rd1),
        .ex_rd2            (ex_rd2),
        .ex_rd             (ex_rd),
        .wb_result         (wb_result),
        .ex_op1_forward    (ex_op1_forward),
        .ex_op2_forward    (ex_op2_forward),
        .ex_busy           (ex_busy),
        .ex_pc_src         (ex_pc_src),
        .ex_pc_target      (ex_pc_target),
        .mem_reg_write     (mem_reg_write),
        .mem_mem_write     (mem_mem_write),
        .mem_result_src    (mem_result_src),
        .mem_alu_result    (mem_alu_result),
        .mem_write_data    (mem_write_data),
        .mem_pc_plus_4     (mem_pc_plus_4),
        .mem_imm_ext       (mem_imm_ext),
        .mem_rd            (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        mem_clear         = 1'b0;
        ex_reg_write      = 1'b0;
        ex_mem_write      = 1'b0;
        ex_jump           = 1'b0;
        ex_jump_cond      = 1'b0;
        ex_jump_cond_type = 3'b000;
        ex_alu_control    = 4'b0000;
        ex_alu_src        = 1'b0;
        ex_result_src     = 2'b00;
        ex_pc             = '0;
        ex_pc_plus_4      = '0;
        ex_imm_ext        = '0;
        ex_rd1            = '0;
        ex_rd2            = '0;
        ex_rd             = '0;
        wb_result         = '0;
        ex_op1_forward    = 2'b00;
        ex_op2_forward    = 2'b00;
    endtask

    // Call just after a rising edge; returns just after the capture edge
    task automatic run_mul(input logic [3:0] ctl, input logic [31:0] a,
                           input logic [31:0] b, output int nbusy,
                           output bit bok);
        nbusy          = 0;
        bok            = 1'b1;
        ex_alu_control = ctl;
        ex_alu_src     = 1'b0;
        ex_reg_write   = 1'b1;
        ex_rd          = 5'd5;
        ex_rd1         = a;
        ex_rd2         = b;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ex_busy) break;
            nbusy++;
            @(posedge clk);
            #1;
            if (mem_reg_write || mem_rd != 5'd0) bok = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        nop();
        reset = 1'b1;
        #12;
        check("rst_busy", {31'd0, ex_busy}, 32'd0);
        check("rst_alu", mem_alu_result, 32'd0);
        check("rst_rw", {31'd0, mem_reg_write}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // ADD 5 + imm 3
        ex_alu_control = 4'b0000;
        ex_alu_src     = 1'b1;
        ex_imm_ext     = 32'd3;
        ex_rd1         = 32'd5;
        ex_rd2         = 32'd9;
        ex_rd          = 5'd3;
        ex_reg_write   = 1'b1;
        ex_result_src  = 2'b01;
        ex_pc_plus_4   = 32'h0000_0104;
        #1;
        check("add_busy0", {31'd0, ex_busy}, 32'd0);
        step();
        check("add_res", mem_alu_result, 32'd8);
        check("add_rd", {27'd0, mem_rd}, 32'd3);
        check("add_rw", {31'd0, mem_reg_write}, 32'd1);
        check("add_pc4", mem_pc_plus_4, 32'h0000_0104);
        check("add_imm", mem_imm_ext, 32'd3);
        check("add_rsrc", {30'd0, mem_result_src}, 32'd1);
        check("add_wdata", mem_write_data, 32'd9);
        check("add_busy1", {31'd0, ex_busy}, 32'd0);
        nop();

        // MUL 7*6 with ex_jump asserted: no redirect on a mul
        ex_jump = 1'b1;
        run_mul(4'b1000, 32'd7, 32'd6, busy_n, bub_ok);
        check("mul_busyn", busy_n, 32'd33);
        check("mul_bubble", {31'd0, bub_ok}, 32'd1);
        check("mul_res", mem_alu_result, 32'd42);
        check("mul_rw", {31'd0, mem_reg_write}, 32'd1);
        check("mul_rd", {27'd0, mem_rd}, 32'd5);
        check("mul_pcsrc", {31'd0, ex_pc_src}, 32'd0);
        ex_jump = 1'b0;

        // Back-to-back MULHU then MUL, no idle gap
        run_mul(4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_n, bub_ok);
        check("mulhu_busyn", busy_n, 32'd33);
        check("mulhu_res", mem_alu_result, 32'hFFFF_FFFE);
        run_mul(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, busy_n, bub_ok);
        check("mullo_busyn", busy_n, 32'd33);
        check("mullo_bubble", {31'd0, bub_ok}, 32'd1);
        check("mullo_res", mem_alu_result, 32'h0000_0001);
        nop();

        // Flush at BUSY cycle 10
        ex_alu_control = 4'b1000;
        ex_reg_write   = 1'b1;
        ex_rd1         = 32'd3;
        ex_rd2         = 32'd4;
        ex_rd          = 5'd7;
        for (int i = 0; i < 10; i++) step();
        check("clr_pre_busy", {31'd0, ex_busy}, 32'd1);
        mem_clear      = 1'b1;
        ex_alu_control = 4'b0000;
        step();
        check("clr_busy", {31'd0, ex_busy}, 32'd0);
        check("clr_rw", {31'd0, mem_reg_write}, 32'd0);
        check("clr_rd", {27'd0, mem_rd}, 32'd0);
        mem_clear = 1'b0;
        step();
        check("clr_add", mem_alu_result, 32'd7);
        check("clr_add_rw", {31'd0, mem_reg_write}, 32'd1);
        nop();

        // Forwarding from MEM into branch-equal
        ex_alu_src = 1'b1;
        ex_rd1     = 32'h0000_0100;
        step();
        check("fw_seed", mem_alu_result, 32'h0000_0100);
        ex_op1_forward    = 2'b10;
        ex_rd1            = 32'h0000_DEAD;
        ex_rd2            = 32'h0000_0100;
        ex_jump_cond      = 1'b1;
        ex_jump_cond_type = 3'b000;
        ex_pc             = 32'h0000_1000;
        ex_imm_ext        = 32'h0000_0040;
        #1;
        check("beq_pcsrc", {31'd0, ex_pc_src}, 32'd1);
        check("beq_target", ex_pc_target, 32'h0000_1040);
        ex_jump_cond_type = 3'b001;
        #1;
        check("bne_pcsrc", {31'd0, ex_pc_src}, 32'd0);
        ex_imm_ext = 32'hFFFF_FFF0;
        #1;
        check("target_neg", ex_pc_target, 32'h0000_0FF0);

        // WB forward on op1, store data is rs2 even with imm selected
        nop();
        ex_op1_forward = 2'b01;
        wb_result      = 32'd20;
        ex_rd1         = 32'd999;
        ex_alu_src     = 1'b1;
        ex_imm_ext     = 32'd2;
        ex_rd2         = 32'h0000_0055;
        ex_mem_write   = 1'b1;
        step();
        check("fwd_wb", mem_alu_result, 32'd22);
        check("st_data", mem_write_data, 32'h0000_0055);
        check("st_we", {31'd0, mem_mem_write}, 32'd1);
        ex_op1_forward = 2'b00;
        ex_op2_forward = 2'b10;
        ex_rd1         = 32'd100;
        ex_alu_src     = 1'b0;
        step();
        check("fwd_mem2", mem_alu_result, 32'd122);
        check("fwd_wdata", mem_write_data, 32'd22);

        // Async reset with a live EX/MEM value and a pending jump
        nop();
        ex_jump = 1'b1;
        #1;
        check("jmp_pcsrc", {31'd0, ex_pc_src}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_alu", mem_alu_result, 32'd0);
        check("arst_wdata", mem_write_data, 32'd0);
        check("arst_pcsrc", {31'd0, ex_pc_src}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nop();
        step();

        // Async reset during BUSY
        ex_alu_control = 4'b1000;
        ex_reg_write   = 1'b1;
        ex_rd1         = 32'd9;
        ex_rd2         = 32'd9;
        for (int i = 0; i < 5; i++) step();
        check("rb_pre_busy", {31'd0, ex_busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rb_busy", {31'd0, ex_busy}, 32'd0);
        check("rb_rw", {31'd0, mem_reg_write}, 32'd0);
        check("rb_rd", {27'd0, mem_rd}, 32'd0);
        check("rb_alu", mem_alu_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        nop();
        ex_alu_src = 1'b1;
        ex_rd1     = 32'd40;
        ex_imm_ext = 32'd2;
        ex_reg_write = 1'b1;
        step();
        check("rb_idle_add", mem_alu_result, 32'd42);
        check("rb_idle_busy", {31'd0, ex_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
